cajero_controlador: RTL
=======================

Name: cajero_controlador

Overview:
Transaction sequencer for the automatic cashier. Takes a card insertion, collects PIN digits from the keypad, and checks them against the card PIN. It counts failed attempts and locks the card after too many, then runs one deposit or withdrawal against the balance loaded from the card. It sits above the keypad/card front-end and drives the dispenser and balance-writeback logic.

Parameters:
PIN_DIGITS, 4, number of BCD digits in a PIN (PIN width = 4*PIN_DIGITS)
MAX_INTENTOS, 3, failed PIN attempts that cause lockout
BALANCE_W, 64, balance width in bits
MONTO_W, 32, transaction amount width in bits
TIMEOUT_CYC, 1024, idle cycles allowed in PIN/TRANS before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
tarjeta_recibida  in  1  card present; sampled only in IDLE
pin_tarjeta  in  4*PIN_DIGITS  correct PIN from card, BCD, MSD in top nibble; captured on card accept
balance_inicial  in  BALANCE_W  balance from card; captured on card accept
digito  in  4  keypad digit, BCD
digito_stb  in  1  one-cycle strobe, digito valid
tipo_trans  in  1  0 = deposit, 1 = withdrawal; valid with monto_stb
monto  in  MONTO_W  amount; valid with monto_stb
monto_stb  in  1  one-cycle strobe, tipo_trans/monto valid
balance  out  BALANCE_W  current balance register
balance_actualizado  out  1  one-cycle pulse, balance changed by a transaction
entregar_dinero  out  1  one-cycle pulse, dispense monto
fondos_insuficientes  out  1  one-cycle pulse, withdrawal rejected
pin_incorrecto  out  1  one-cycle pulse per failed PIN check
advertencia  out  1  level, exactly one attempt remains
bloqueo  out  1  level, card locked
fin  out  1  one-cycle pulse, session ended (normal or timeout)

Behaviour:
- All outputs are registered. The reset value of every output, balance, counters and PIN shift register is 0. State resets to IDLE.
- States: IDLE, PIN, CHECK, TRANS, DEPOSITO, RETIRO, FIN, BLOQUEO. Each state is one cycle except IDLE, PIN, TRANS and BLOQUEO.
- IDLE: when tarjeta_recibida=1 at an edge, capture pin_tarjeta and balance_inicial (balance output updates at that edge). Clear the digit count, attempts and timeout counter. Go to PIN.
- PIN: each digito_stb with digito<=9 shifts the digit into the entry register from the LSB side (first digit ends up MSD) and increments the count. If digito>9, the strobe is ignored and neither count nor timeout changes. On the strobe that makes count==PIN_DIGITS, go to CHECK.
- CHECK: compare the entry register to the captured PIN.
  - Match: go to TRANS; clear attempts and advertencia.
  - Mismatch: attempts+1 and pin_incorrecto=1 for one cycle.
    - If attempts reaches MAX_INTENTOS, go to BLOQUEO.
    - Otherwise go to PIN with count and entry cleared. advertencia=1 if attempts==MAX_INTENTOS-1.
  - pin_incorrecto is visible in the 2nd cycle after the edge that sampled the last digit.
- TRANS: on monto_stb, capture tipo_trans and monto and go to DEPOSITO (0) or RETIRO (1).
- DEPOSITO: balance <= balance + zero-extended monto, saturating at all-ones. balance_actualizado=1. Go to FIN.
- RETIRO:
  - If monto <= balance: balance -= monto, entregar_dinero=1, balance_actualizado=1.
  - Otherwise: balance unchanged, fondos_insuficientes=1.
  - Go to FIN in either case.
- FIN: fin=1 for one cycle. Go to IDLE. advertencia cleared.
- BLOQUEO: bloqueo=1 and advertencia=0. All inputs ignored. Only reset exits.
- Timeout: in PIN or TRANS, the counter increments each cycle and clears on any accepted strobe. Reaching TIMEOUT_CYC goes to FIN: fin pulses, balance untouched, no other pulses.
- Strobes outside their state are ignored: digito_stb outside PIN, monto_stb outside TRANS, tarjeta_recibida outside IDLE. digito_stb and monto_stb in the same cycle: only the one valid for the current state counts.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, including bloqueo; no pulse is emitted.

Test Plan:
- Card pin_tarjeta=0x1234, balance 500, digits 1,2,3,4, deposit 250 -> balance_actualizado pulse, balance=750, fin 1 cycle later, state IDLE.
- Same card, correct PIN, withdraw 600 -> fondos_insuficientes pulse, balance stays 500, entregar_dinero stays 0, fin pulse.
- Wrong PIN 9999 twice, then 1234, withdraw 200 -> pin_incorrecto pulses twice; advertencia=1 after the 2nd failure and 0 after the match; entregar_dinero pulse; balance=300.
- Wrong PIN three times -> third pin_incorrecto then bloqueo=1 held; further card/digit/amount strobes cause no change; reset clears bloqueo.
- Digit 0xA inserted mid-PIN plus digito_stb during CHECK -> both ignored, count unaffected, check result unchanged. Balance all-ones, deposit 5 -> saturates at all-ones.
- Card accepted, no keypad activity for TIMEOUT_CYC cycles -> fin pulse, no balance change. Reset asserted during RETIRO -> no entregar_dinero, all outputs 0.

Source files
------------

// File: rtl/cajero_controlador.sv
// Transaction sequencer for the automatic cashier.
// Flow: card accept -> PIN entry -> PIN check (with lockout) -> one deposit or
// withdrawal -> session end. Every output is registered. A pulse output is
// raised by the edge that leaves the state owning that action, so it is
// visible for the one cycle after that edge.
//
// Strobe protocol: digito_stb, monto_stb and tarjeta_recibida carry no ready
// signal. The value that goes with a strobe is taken in the same cycle as the
// strobe. A strobe is accepted only in the state that owns it: tarjeta_recibida
// in IDLE, digito_stb in PIN, monto_stb in TRANS. In every other state the
// strobe is dropped without side effects.
//
// estado_dbg shows the state register for checkers. The encoding is
// IDLE=0, PIN=1, CHECK=2, TRANS=3, DEPOSITO=4, RETIRO=5, FIN=6, BLOQUEO=7.
module cajero_controlador #(
  parameter int PIN_DIGITS   = 4,
  parameter int MAX_INTENTOS = 3,
  parameter int BALANCE_W    = 64,
  parameter int MONTO_W      = 32,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic [4*PIN_DIGITS-1:0] pin_tarjeta,
  input  logic [BALANCE_W-1:0]    balance_inicial,
  input  logic [3:0]              digito,
  input  logic                    digito_stb,
  input  logic                    tipo_trans,
  input  logic [MONTO_W-1:0]      monto,
  input  logic                    monto_stb,
  output logic [BALANCE_W-1:0]    balance,
  output logic                    balance_actualizado,
  output logic                    entregar_dinero,
  output logic                    fondos_insuficientes,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic                    fin,
  output logic [2:0]              estado_dbg
);

  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIN_DIGITS - 1);
  localparam logic [INT_W-1:0] INT_MAX  = INT_W'(MAX_INTENTOS);
  localparam logic [INT_W-1:0] INT_WARN = INT_W'(MAX_INTENTOS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN      = 3'd1,
    CHECK    = 3'd2,
    TRANS    = 3'd3,
    DEPOSITO = 3'd4,
    RETIRO   = 3'd5,
    FIN      = 3'd6,
    BLOQUEO  = 3'd7
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [PIN_W-1:0]     pin_ref_q, pin_ref_d;
  logic [PIN_W-1:0]     entrada_q, entrada_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [INT_W-1:0]     intentos_q, intentos_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 tipo_q, tipo_d;
  logic [MONTO_W-1:0]   monto_q, monto_d;
  logic [BALANCE_W-1:0] balance_q, balance_d;
  logic                 act_q, act_d;
  logic                 entregar_q, entregar_d;
  logic                 fondos_q, fondos_d;
  logic                 pin_inc_q, pin_inc_d;
  logic                 adv_q, adv_d;
  logic                 bloq_q, bloq_d;
  logic                 fin_q, fin_d;

  logic                 digito_ok;
  logic [INT_W-1:0]     intentos_inc;
  logic [BALANCE_W:0]   suma;
  logic [BALANCE_W-1:0] monto_ext;
  logic                 cabe;

  // Arithmetic shared by the deposit and withdrawal states.
  // suma keeps the carry so that a deposit can saturate instead of wrapping.
  always_comb begin
    digito_ok    = (digito <= 4'd9);
    intentos_inc = intentos_q + 1'b1;
    monto_ext    = BALANCE_W'(monto_q);
    suma         = {1'b0, balance_q} + (BALANCE_W + 1)'(monto_q);
    cabe         = (monto_ext <= balance_q);
  end

  // Next-state and next-output logic for the session sequencer.
  always_comb begin
    estado_d   = estado_q;
    pin_ref_d  = pin_ref_q;
    entrada_d  = entrada_q;
    cnt_d      = cnt_q;
    intentos_d = intentos_q;
    tmo_d      = tmo_q;
    tipo_d     = tipo_q;
    monto_d    = monto_q;
    balance_d  = balance_q;
    adv_d      = adv_q;
    bloq_d     = bloq_q;
    act_d      = 1'b0;
    entregar_d = 1'b0;
    fondos_d   = 1'b0;
    pin_inc_d  = 1'b0;
    fin_d      = 1'b0;

    case (estado_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          pin_ref_d  = pin_tarjeta;
          balance_d  = balance_inicial;
          entrada_d  = '0;
          cnt_d      = '0;
          intentos_d = '0;
          tmo_d      = '0;
          estado_d   = PIN;
        end
      end

      PIN: begin
        if (digito_stb && digito_ok) begin
          // The newest digit enters at the LSB, so the first digit typed
          // ends up in the most significant nibble.
          entrada_d = PIN_W'({entrada_q, digito});
          cnt_d     = cnt_q + 1'b1;
          tmo_d     = '0;
          if (cnt_q == CNT_LAST) begin
            estado_d = CHECK;
          end
        end else if (digito_stb) begin
          // A non-BCD key is dropped. It leaves the idle timer unchanged too.
          tmo_d = tmo_q;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d    = '0;
          estado_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CHECK: begin
        if (entrada_q == pin_ref_q) begin
          intentos_d = '0;
          adv_d      = 1'b0;
          tmo_d      = '0;
          estado_d   = TRANS;
        end else begin
          intentos_d = intentos_inc;
          pin_inc_d  = 1'b1;
          if (intentos_inc == INT_MAX) begin
            adv_d    = 1'b0;
            bloq_d   = 1'b1;
            estado_d = BLOQUEO;
          end else begin
            adv_d     = (intentos_inc == INT_WARN);
            entrada_d = '0;
            cnt_d     = '0;
            tmo_d     = '0;
            estado_d  = PIN;
          end
        end
      end

      TRANS: begin
        if (monto_stb) begin
          tipo_d   = tipo_trans;
          monto_d  = monto;
          tmo_d    = '0;
          estado_d = tipo_trans ? RETIRO : DEPOSITO;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d    = '0;
          estado_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DEPOSITO: begin
        balance_d = suma[BALANCE_W] ? {BALANCE_W{1'b1}} : suma[BALANCE_W-1:0];
        act_d     = 1'b1;
        estado_d  = FIN;
      end

      RETIRO: begin
        if (cabe) begin
          balance_d  = balance_q - monto_ext;
          entregar_d = 1'b1;
          act_d      = 1'b1;
        end else begin
          fondos_d = 1'b1;
        end
        estado_d = FIN;
      end

      FIN: begin
        fin_d    = 1'b1;
        adv_d    = 1'b0;
        estado_d = IDLE;
      end

      BLOQUEO: begin
        // Locked card: every input is ignored, and only reset leaves this state.
        bloq_d = 1'b1;
        adv_d  = 1'b0;
      end

      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      pin_ref_q  <= '0;
      entrada_q  <= '0;
      cnt_q      <= '0;
      intentos_q <= '0;
      tmo_q      <= '0;
      tipo_q     <= 1'b0;
      monto_q    <= '0;
      balance_q  <= '0;
      act_q      <= 1'b0;
      entregar_q <= 1'b0;
      fondos_q   <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pin_ref_q  <= pin_ref_d;
      entrada_q  <= entrada_d;
      cnt_q      <= cnt_d;
      intentos_q <= intentos_d;
      tmo_q      <= tmo_d;
      tipo_q     <= tipo_d;
      monto_q    <= monto_d;
      balance_q  <= balance_d;
      act_q      <= act_d;
      entregar_q <= entregar_d;
      fondos_q   <= fondos_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      fin_q      <= fin_d;
    end
  end

  assign balance              = balance_q;
  assign balance_actualizado  = act_q;
  assign entregar_dinero      = entregar_q;
  assign fondos_insuficientes = fondos_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloq_q;
  assign fin                  = fin_q;
  assign estado_dbg           = estado_q;

endmodule
